// File: rtl/gray_stream_decoder.sv
// Receives MSB-first Gray-coded symbols, reassembles one word, converts it to binary and
// presents it through a single-entry valid/ready register with framing and overflow flags.
module gray_stream_decoder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SYM_W-1:0]  ss,
  input  logic              ss_vld,
  input  logic              ss_sof,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              frame_err,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned Syms    = DATA_W / SYM_W;
  localparam int unsigned SymCntW = (Syms > 1) ? $clog2(Syms) : 1;
  localparam int unsigned ShiftW  = DATA_W - SYM_W;
  localparam logic [SymCntW-1:0] LastSym = SymCntW'(Syms - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [SymCntW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_vld_q;
  logic                frame_err_q;
  logic                ovf_q;
  logic [CNT_W-1:0]    word_cnt_q;

  logic                sof_take, cont_take, word_done, frame_err_d;
  logic                load, drop, deq;
  logic [DATA_W-1:0]   gray_word, bin_word;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ss_sof in StShift restarts the word without leaving StShift
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sof_take)  state_d = StShift;
      StShift: if (word_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    sof_take    = ss_vld & ss_sof;
    cont_take   = ss_vld & ~ss_sof & (state_q == StShift);
    word_done   = cont_take & (sym_cnt_q == LastSym);
    frame_err_d = sof_take & (state_q == StShift);
  end

  // Symbol assembly and Gray-to-binary: each binary bit is the parity of all Gray bits above it
  always_comb begin
    gray_word = {shift_q, ss};
    for (int i = 0; i < int'(DATA_W); i++) begin
      bin_word[i] = ^(gray_word >> i);
    end
    shift_d   = shift_q;
    sym_cnt_d = sym_cnt_q;
    if (sof_take) begin
      shift_d   = ShiftW'(ss);
      sym_cnt_d = SymCntW'(1);
    end else if (cont_take) begin
      shift_d   = gray_word[ShiftW-1:0];
      sym_cnt_d = word_done ? '0 : sym_cnt_q + SymCntW'(1);
    end
  end

  always_comb begin
    deq  = dout_vld_q & dout_rdy;
    load = word_done & (~dout_vld_q | dout_rdy);
    drop = word_done & dout_vld_q & ~dout_rdy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      sym_cnt_q   <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      shift_q     <= shift_d;
      sym_cnt_q   <= sym_cnt_d;
      frame_err_q <= frame_err_d;
      if (load) dout_q <= bin_word;
      dout_vld_q  <= load | (dout_vld_q & ~dout_rdy);
      // A new overflow wins over a simultaneous clear
      ovf_q       <= drop | (ovf_q & ~ovf_clr);
      if (deq) word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Randomised scoreboard bench for gray_stream_decoder; a second instance with a 4-bit
// word counter exercises counter wrap within a short run.
module tb_gray_stream_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ss;
  logic        ss_vld, ss_sof, dout_rdy, ovf_clr;
  logic [31:0] dout, dout4;
  logic        dout_vld, frame_err, ovf;
  logic        dout_vld4, frame_err4, ovf4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  always #5 clk = ~clk;

  gray_stream_decoder #(.DATA_W(32), .SYM_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ss(ss), .ss_vld(ss_vld), .ss_sof(ss_sof),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .frame_err(frame_err),
    .ovf(ovf), .ovf_clr(ovf_clr), .word_cnt(word_cnt)
  );

  gray_stream_decoder #(.DATA_W(32), .SYM_W(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .ss(ss), .ss_vld(ss_vld), .ss_sof(ss_sof),
    .dout(dout4), .dout_vld(dout_vld4), .dout_rdy(dout_rdy), .frame_err(frame_err4),
    .ovf(ovf4), .ovf_clr(ovf_clr), .word_cnt(word_cnt4)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;
  int          exp_cnt = 0;
  int          delivered_exp = 0;
  int          fe_seen = 0;
  int          fe_exp = 0;
  bit          mid_word = 0;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int k = 1; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted output word
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (frame_err) fe_seen++;
      if (dout_vld && dout_rdy) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %0h expected no word", dout);
        end else begin
          exp_w = sb.pop_front();
          chk("dout", 64'(dout), 64'(exp_w));
        end
        chk("word_cnt", 64'(word_cnt), 64'(exp_cnt % 65536));
        chk("word_cnt4", 64'(word_cnt4), 64'(exp_cnt % 16));
        exp_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ss_vld = 1'b0;
    ss_sof = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send_syms(input logic [31:0] g, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4 && int'($urandom_range(0, 99)) < gap; k++) begin
        ss_vld = 1'b0;
        ss_sof = 1'b0;
        cyc();
      end
      if (i == 0 && mid_word) fe_exp++;
      ss     = g[31-2*i -: 2];
      ss_vld = 1'b1;
      ss_sof = (i == 0);
      cyc();
    end
    ss_vld   = 1'b0;
    ss_sof   = 1'b0;
    mid_word = (n > 0 && n < 16);
  endtask

  task automatic send_word(input logic [31:0] g, input int gap, input bit deliver);
    send_syms(g, 16, gap);
    if (deliver) begin
      sb.push_back(gray2bin(g));
      delivered_exp++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
    chk({tag, "_dout_vld"}, 64'(dout_vld), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b, c;
    reset = 1'b0; ss = '0; ss_vld = 1'b0; ss_sof = 1'b0; dout_rdy = 1'b1; ovf_clr = 1'b0;
    #12;
    check_reset_outputs("rst");
    #1 reset = 1'b1;
    cyc();

    // Single word, latency and one-cycle valid
    send_word(32'h1B2E7D44, 0, 1);
    chk("t2_vld_on_last_edge", 64'(dout_vld), 64'd1);
    chk("t2_dout", 64'(dout), 64'h12345678);
    cyc();
    chk("t2_vld_drops", 64'(dout_vld), 64'd0);
    chk("t2_word_cnt", 64'(word_cnt), 64'd1);

    // Extremes with random gaps
    send_word(32'h80000000, 40, 1);
    send_word(32'h00000003, 40, 1);
    idle(2);

    // Framing error: sof on the 7th dibit
    send_syms($urandom, 6, 0);
    send_word(32'hC0FFEE11, 20, 1);
    idle(2);
    chk("t4_frame_err_pulses", 64'(fe_seen), 64'(fe_exp));

    // Backpressure and overflow
    dout_rdy = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    send_word(a, 10, 1);
    send_word(b, 10, 0);
    idle(3);
    chk("t5_ovf_set", 64'(ovf), 64'd1);
    chk("t5_vld_held", 64'(dout_vld), 64'd1);
    chk("t5_dout_stable", 64'(dout), 64'(gray2bin(a)));
    ovf_clr = 1'b1;
    send_word(c, 0, 0);
    ovf_clr = 1'b0;
    chk("t5_set_wins", 64'(ovf), 64'd1);
    chk("t5_dout_stable2", 64'(dout), 64'(gray2bin(a)));
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", 64'(ovf), 64'd0);
    dout_rdy = 1'b1;
    cyc();
    chk("t5_vld_after_accept", 64'(dout_vld), 64'd0);
    chk("t5_word_cnt", 64'(word_cnt), 64'(delivered_exp));

    // Asynchronous reset mid-word with a full output and sticky ovf
    dout_rdy = 1'b0;
    send_word($urandom, 0, 1);
    send_word($urandom, 0, 0);
    send_syms($urandom, 5, 0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("t1");
    #10 reset = 1'b1;
    mid_word = 0;
    delivered_exp = 0;
    dout_rdy = 1'b1;
    cyc();
    send_word(32'h1B2E7D44, 5, 1);
    idle(2);
    chk("t1_recover_cnt", 64'(word_cnt), 64'd1);

    // Back-to-back words, wraps the narrow counter
    for (int i = 0; i < 40; i++) send_word($urandom, 0, 1);
    idle(2);

    // Random traffic with occasional aborted frames
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) send_syms($urandom, int'($urandom_range(1, 15)), 20);
      send_word($urandom, 30, 1);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) cyc();
    idle(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("delivered", 64'(exp_cnt), 64'(delivered_exp));
    chk("final_word_cnt", 64'(word_cnt), 64'(delivered_exp % 65536));
    chk("final_word_cnt4", 64'(word_cnt4), 64'(delivered_exp % 16));
    chk("frame_err_total", 64'(fe_seen), 64'(fe_exp));
    chk("final_ovf", 64'(ovf), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
